// File: rtl/latrnq_array_pkg.sv
// Shared sizing helpers and reset-synchroniser depth for the latrnq_array register file.
package latrnq_array_pkg;

   localparam int RST_SYNC_DEPTH = 2;

   function automatic int lat_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int lat_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/latrnq_array_entry.sv
// One storage slot: WIDTH data bits plus a valid bit that only reset or a clear can drop.
module latrnq_array_entry #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] data_o,
   output logic             vld_o
);

   logic             vld_d, vld_q;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      vld_d = vld_q;
      if (clr_i) begin
         vld_d = 1'b0;
      end else if (we_i) begin
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // Data bits are qualified by the valid bit, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         data_q <= d_i;
      end
   end

   assign data_o = data_q;
   assign vld_o  = vld_q;

endmodule

// File: rtl/latrnq_array.sv
// Small register file with per-entry valid bits, registered read port, optional write-to-read bypass.
module latrnq_array
   import latrnq_array_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 8,
   parameter  int BYPASS = 1,
   localparam int AW     = lat_aw(DEPTH),
   localparam int CW     = lat_cw(DEPTH)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             WE,
   input  logic [AW-1:0]    WA,
   input  logic [WIDTH-1:0] D,
   input  logic             RE,
   input  logic [AW-1:0]    RA,
   input  logic             CLR,
   output logic [WIDTH-1:0] Q,
   output logic             QV,
   output logic [CW-1:0]    CNT
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [RST_SYNC_DEPTH-1:0] rsync_q;
   logic                      wr_run, rd_run;

   logic [WIDTH-1:0] ent_data [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [DEPTH-1:0] ent_we;

   logic             wa_ok, wr_ok, clr_en, re_en, wa_vld;
   logic [WIDTH-1:0] rd_data;
   logic             rd_vld;

   logic [WIDTH-1:0] q_d, q_q;
   logic             qv_d, qv_q;
   logic [CW-1:0]    cnt_d, cnt_q;

   // Writes open after the first synchroniser stage, reads only once release is fully synchronised.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         rsync_q <= '0;
      end else begin
         rsync_q <= {rsync_q[RST_SYNC_DEPTH-2:0], 1'b1};
      end
   end

   assign wr_run = rsync_q[0];
   assign rd_run = rsync_q[RST_SYNC_DEPTH-1];

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      latrnq_array_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk_i  (CLK),
         .rst_ni (RN),
         .we_i   (ent_we[g]),
         .clr_i  (clr_en),
         .d_i    (D),
         .data_o (ent_data[g]),
         .vld_o  (ent_vld[g])
      );
   end

   always_comb begin
      wa_ok   = ({1'b0, WA} < DEPTH_W);
      clr_en  = CLR & wr_run;
      wr_ok   = WE & wr_run & ~CLR & wa_ok;
      re_en   = RE & rd_run;
      ent_we  = '0;
      wa_vld  = 1'b0;
      rd_data = '0;
      rd_vld  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (WA == AW'(i)) begin
            ent_we[i] = wr_ok;
            wa_vld    = ent_vld[i];
         end
         if (RA == AW'(i)) begin
            rd_data = ent_data[i];
            rd_vld  = ent_vld[i];
         end
      end
      if (!rd_vld) begin
         rd_data = '0;
      end
      // A dropped write (clear or out-of-range address) is never forwarded.
      if ((BYPASS != 0) && wr_ok && (WA == RA)) begin
         rd_data = D;
         rd_vld  = 1'b1;
      end
   end

   always_comb begin
      q_d   = q_q;
      qv_d  = qv_q;
      cnt_d = cnt_q;
      if (re_en) begin
         q_d  = rd_data;
         qv_d = rd_vld;
      end
      if (clr_en) begin
         cnt_d = '0;
      end else if (wr_ok && !wa_vld) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         q_q   <= '0;
         qv_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         qv_q  <= qv_d;
         cnt_q <= cnt_d;
      end
   end

   assign Q   = q_q;
   assign QV  = qv_q;
   assign CNT = cnt_q;

endmodule

// File: tb/tb_latrnq_array.sv
// Drives three latrnq_array variants (bypass, no bypass, DEPTH=6) with one stimulus stream.
module tb_latrnq_array;

   typedef struct {
      int         inst;
      logic [7:0] q;
      logic       qv;
   } exp_t;

   logic       clk;
   logic       rn;
   logic       we;
   logic [2:0] wa;
   logic [7:0] d;
   logic       re;
   logic [2:0] ra;
   logic       clr;

   logic [7:0] q0, q1, q2;
   logic       qv0, qv1, qv2;
   logic [3:0] cnt0, cnt1;
   logic [2:0] cnt2;

   int checks = 0;
   int errors = 0;

   exp_t       sbq[$];
   logic [7:0] mem [3][8];
   logic       mv  [3][8];
   int         mcnt[3];
   logic [7:0] mq  [3];
   logic       mqv [3];
   int         rs;
   int         dep [3] = '{8, 8, 6};
   bit         byp [3] = '{1'b1, 1'b0, 1'b1};

   latrnq_array #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) u_b1 (
      .CLK(clk), .RN(rn), .WE(we), .WA(wa), .D(d), .RE(re), .RA(ra), .CLR(clr),
      .Q(q0), .QV(qv0), .CNT(cnt0));

   latrnq_array #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) u_b0 (
      .CLK(clk), .RN(rn), .WE(we), .WA(wa), .D(d), .RE(re), .RA(ra), .CLR(clr),
      .Q(q1), .QV(qv1), .CNT(cnt1));

   latrnq_array #(.WIDTH(8), .DEPTH(6), .BYPASS(1)) u_d6 (
      .CLK(clk), .RN(rn), .WE(we), .WA(wa), .D(d), .RE(re), .RA(ra), .CLR(clr),
      .Q(q2), .QV(qv2), .CNT(cnt2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] get_q(input int k);
      return (k == 0) ? {24'd0, q0} : (k == 1) ? {24'd0, q1} : {24'd0, q2};
   endfunction

   function automatic logic [31:0] get_qv(input int k);
      return (k == 0) ? {31'd0, qv0} : (k == 1) ? {31'd0, qv1} : {31'd0, qv2};
   endfunction

   function automatic logic [31:0] get_cnt(input int k);
      return (k == 0) ? {28'd0, cnt0} : (k == 1) ? {28'd0, cnt1} : {29'd0, cnt2};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      rs = 0;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 8; j++) mv[k][j] = 1'b0;
         mcnt[k] = 0;
         mq[k]   = 8'h00;
         mqv[k]  = 1'b0;
      end
      sbq.delete();
   endtask

   task automatic model_edge();
      exp_t e;
      logic wr, rd;
      if (!rn) begin
         rs = 0;
         return;
      end
      for (int k = 0; k < 3; k++) begin
         wr = we && (rs >= 1) && !clr && (int'(wa) < dep[k]);
         rd = re && (rs >= 2);
         if (rd) begin
            e.inst = k;
            if (int'(ra) >= dep[k]) begin
               e.q = 8'h00; e.qv = 1'b0;
            end else if (byp[k] && wr && (wa == ra)) begin
               e.q = d; e.qv = 1'b1;
            end else if (mv[k][ra]) begin
               e.q = mem[k][ra]; e.qv = 1'b1;
            end else begin
               e.q = 8'h00; e.qv = 1'b0;
            end
            sbq.push_back(e);
            mq[k]  = e.q;
            mqv[k] = e.qv;
         end
         if (clr && (rs >= 1)) begin
            for (int j = 0; j < 8; j++) mv[k][j] = 1'b0;
            mcnt[k] = 0;
         end else if (wr) begin
            if (!mv[k][wa]) mcnt[k]++;
            mv[k][wa]  = 1'b1;
            mem[k][wa] = d;
         end
      end
      if (rs < 2) rs++;
   endtask

   task automatic check_outputs();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk($sformatf("rd_q%0d", e.inst), get_q(e.inst), {24'd0, e.q});
         chk($sformatf("rd_qv%0d", e.inst), get_qv(e.inst), {31'd0, e.qv});
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold_q%0d", k), get_q(k), {24'd0, mq[k]});
         chk($sformatf("hold_qv%0d", k), get_qv(k), {31'd0, mqv[k]});
         chk($sformatf("cnt%0d", k), get_cnt(k), 32'(mcnt[k]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] v);
      we = 1'b1; wa = a; d = v;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a);
      re = 1'b1; ra = a;
      step();
      re = 1'b0;
   endtask

   initial begin
      rn = 1'b1; we = 1'b0; wa = '0; d = '0; re = 1'b0; ra = '0; clr = 1'b0;
      reset_model();
      #2 rn = 1'b0;
      #1;
      check_outputs();

      // Reset held with a write pending, then the first honoured write on the 2nd edge.
      we = 1'b1; wa = 3'd3; d = 8'hA5;
      repeat (3) step();
      chk("rst_cnt", {28'd0, cnt0}, 32'd0);
      chk("rst_q", {24'd0, q0}, 32'd0);
      chk("rst_qv", {31'd0, qv0}, 32'd0);
      rn = 1'b1;
      step();
      chk("rel_edge1_cnt", {28'd0, cnt0}, 32'd0);
      step();
      chk("rel_edge2_cnt", {28'd0, cnt0}, 32'd1);
      we = 1'b0;

      // Basic write/read and a never-written entry.
      wr(3'd2, 8'h11);
      rd(3'd2);
      chk("rd2_q", {24'd0, q0}, 32'h11);
      chk("rd2_qv", {31'd0, qv0}, 32'd1);
      rd(3'd5);
      chk("rd5_q", {24'd0, q0}, 32'h0);
      chk("rd5_qv", {31'd0, qv0}, 32'd0);
      step();

      // Same-cycle write and read of one address.
      wr(3'd4, 8'h77);
      we = 1'b1; wa = 3'd4; d = 8'h3C; re = 1'b1; ra = 3'd4;
      step();
      we = 1'b0; re = 1'b0;
      chk("byp1_q", {24'd0, q0}, 32'h3C);
      chk("byp0_q", {24'd0, q1}, 32'h77);
      chk("byp_d6_q", {24'd0, q2}, 32'h3C);
      rd(3'd4);
      chk("after_byp0_q", {24'd0, q1}, 32'h3C);

      // Out-of-range address on the DEPTH=6 instance.
      wr(3'd7, 8'hEE);
      chk("d6_oor_cnt", {29'd0, cnt2}, 32'd3);
      chk("d8_wr7_cnt", {28'd0, cnt0}, 32'd4);
      rd(3'd7);
      chk("d6_oor_q", {24'd0, q2}, 32'h0);
      chk("d6_oor_qv", {31'd0, qv2}, 32'd0);
      chk("d8_rd7_q", {24'd0, q0}, 32'hEE);

      // Fill, rewrite, then clear colliding with a write and a read.
      for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h20 + i));
      wr(3'd0, 8'h55);
      chk("full_cnt", {28'd0, cnt0}, 32'd8);
      chk("full_cnt_d6", {29'd0, cnt2}, 32'd6);
      clr = 1'b1; we = 1'b1; wa = 3'd1; d = 8'h99; re = 1'b1; ra = 3'd1;
      step();
      clr = 1'b0; we = 1'b0; re = 1'b0;
      chk("clr_rd_q", {24'd0, q0}, 32'h21);
      chk("clr_rd_qv", {31'd0, qv0}, 32'd1);
      chk("clr_cnt", {28'd0, cnt0}, 32'd0);
      rd(3'd1);
      chk("post_clr_qv", {31'd0, qv0}, 32'd0);
      chk("post_clr_q", {24'd0, q0}, 32'h0);

      // Reset pulse between a read request and its Q update.
      wr(3'd6, 8'h5A);
      re = 1'b1; ra = 3'd6;
      #3 rn = 1'b0;
      #1;
      reset_model();
      chk("abort_q", {24'd0, q0}, 32'h0);
      chk("abort_qv", {31'd0, qv0}, 32'd0);
      check_outputs();
      #1 rn = 1'b1;
      step();
      re = 1'b0;
      step();
      step();
      chk("no_stale_q", {24'd0, q0}, 32'h0);
      rd(3'd6);
      chk("no_stale_rd_qv", {31'd0, qv0}, 32'd0);
      wr(3'd6, 8'hC3);
      rd(3'd6);
      chk("post_rst_rd_q", {24'd0, q0}, 32'hC3);
      chk("post_rst_cnt", {28'd0, cnt0}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/latrnq_array.md
LATRNQ_ARRAY -- requirements
Module: latrnq_array

Interface
REQ-001 Parameter WIDTH, default 8, data bits per entry (1..64).
REQ-002 Parameter DEPTH, default 8, number of entries (2..64, need not be a power of 2).
REQ-003 Parameter BYPASS, default 1, 1 = a same-cycle write to the read address is forwarded to Q; 0 = Q returns the pre-write contents.
REQ-004 Derived AW = clog2(DEPTH); CW = clog2(DEPTH+1).
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RN  input  1  asynchronous active-low reset.
REQ-007 WE  input  1  write enable.
REQ-008 WA  input  AW  write address.
REQ-009 D  input  WIDTH  write data.
REQ-010 RE  input  1  read enable.
REQ-011 RA  input  AW  read address.
REQ-012 CLR  input  1  synchronous clear of all valid bits.
REQ-013 Q  output  WIDTH  registered read data.
REQ-014 QV  output  1  registered valid flag for Q.
REQ-015 CNT  output  CW  number of currently valid entries.

Function
REQ-016 Each entry SHALL hold WIDTH data bits plus one valid bit.
REQ-017 WE=1, CLR=0 and WA<DEPTH at a rising edge SHALL store D at entry WA and set its valid bit.
REQ-018 WE=1 with WA>=DEPTH SHALL be ignored: no state change, CNT unchanged.
REQ-019 RE=1 SHALL update Q/QV exactly one cycle later (latency 1) with the entry's data and valid bit.
REQ-020 A read of an invalid entry, or with RA>=DEPTH, SHALL give Q=0, QV=0.
REQ-021 RE=0 SHALL hold Q and QV at their previous values.
REQ-022 Same-cycle write and read to the same address: BYPASS=1 gives Q=D, QV=1; BYPASS=0 gives the old data and valid bit.
REQ-023 CLR=1 SHALL clear every valid bit and set CNT=0 at the edge; entry data bits are not required to clear.
REQ-024 CLR and WE in the same cycle: CLR wins and the write is dropped.
REQ-025 CLR and RE in the same cycle: the read returns pre-clear contents; with BYPASS=1, a write in that cycle is not forwarded, because it is dropped.
REQ-026 CNT SHALL increment by 1 on a write to an invalid entry, stay unchanged on a write to a valid entry, and never exceed DEPTH.
REQ-027 Entries SHALL never invalidate individually; only CLR or RN clears valid bits.

Reset
REQ-028 RN=0 SHALL asynchronously force all valid bits to 0, Q=0, QV=0, CNT=0, independent of CLK.
REQ-029 While RN=0, writes and reads SHALL be ignored.
REQ-030 Reset deassertion SHALL be synchronised inside the block, so the first write is honoured on the second rising CLK edge after RN rises.
REQ-031 RN asserted mid-operation SHALL abort any pending read; Q stays 0 until the next read completes after reset.

Structure
REQ-032 Package latrnq_array_pkg SHALL hold the clog2-based width functions and the reset-synchroniser depth constant (2).
REQ-033 One sub-module latrnq_array_entry (WIDTH data + valid, async-clear valid, write enable, sync clear) SHALL be instantiated DEPTH times.
REQ-034 The read mux, the bypass compare and the CNT logic SHALL live in the top level.

Verification
REQ-035 RN=0 for 3 cycles with WE=1 -> CNT=0, Q=0, QV=0; after RN rises, a write of 0xA5 to addr 3 on the 2nd edge is accepted and CNT=1.
REQ-036 Write 0x11 to addr 2, then read addr 2 -> Q=0x11, QV=1 one cycle after RE; read addr 5 (never written) -> Q=0, QV=0.
REQ-037 BYPASS=1: write 0x3C and read addr 4 in the same cycle, with 0x77 previously stored -> Q=0x3C; BYPASS=0, same stimulus -> Q=0x77.
REQ-038 Fill all 8 entries, rewrite addr 0 -> CNT=8, not 9; then CLR with WE to addr 1 in the same cycle -> CNT=0 and a read of addr 1 gives QV=0.
REQ-039 DEPTH=6: write to WA=7 -> CNT unchanged; read RA=7 -> Q=0, QV=0.
REQ-040 Pulse RN low between RE and Q update -> Q=0, QV=0 immediately; no stale data appears after reset.
